// File: rtl/fnn_pkg.sv
// Shared types and default sizes for the feed-forward network blocks.
// Used by the image loader and the layer modules.
package fnn_pkg;

  localparam int IMG_WORDS = 784;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    LOAD,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream handshake plus assembled-image bundle for the loader.
// master = pixel source / network side, slave = image_loader.
interface image_loader_if
  import fnn_pkg::*;
#(
  parameter int weightNo  = IMG_WORDS,
  parameter int dataWidth = DATA_W
);

  logic [dataWidth-1:0]          pix_in;
  logic                          pix_valid;
  logic                          pix_ready;
  logic                          pix_last;
  logic [weightNo*dataWidth-1:0] img_out;
  logic                          img_load;
  logic                          img_ack;
  logic                          busy;
  logic                          frame_err;

  modport master (
    output pix_in, pix_valid, pix_last, img_ack,
    input  pix_ready, img_out, img_load, busy, frame_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_last, img_ack,
    output pix_ready, img_out, img_load, busy, frame_err
  );

endinterface

// File: rtl/image_loader.sv
// Serial pixel stream to flat image vector for the network input layer.
// Fills weightNo words, pulses img_load, holds until img_ack.
module image_loader
  import fnn_pkg::*;
#(
  parameter int weightNo  = IMG_WORDS,
  parameter int dataWidth = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  image_loader_if.slave    bus
);

  localparam int CW = (weightNo > 1) ? $clog2(weightNo) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(weightNo - 1);

  loader_state_t                 r_state;
  logic [CW-1:0]                 r_cnt;
  logic [weightNo*dataWidth-1:0] r_img;
  logic                          r_load;
  logic                          r_err;
  logic                          w_acc;

  assign w_acc         = (r_state == FILL) && bus.pix_valid;
  assign bus.pix_ready = (r_state == FILL);
  assign bus.busy      = (r_state == LOAD) || (r_state == HOLD);
  assign bus.img_out   = r_img;
  assign bus.img_load  = r_load;
  assign bus.frame_err = r_err;

  // Loader FSM: word capture, frame counting, load/error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_img   <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: r_state <= FILL;
        FILL: begin
          if (w_acc) begin
            r_img[int'(r_cnt)*dataWidth +: dataWidth] <= bus.pix_in;
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_load  <= 1'b1;
              r_state <= LOAD;
            end else if (bus.pix_last) begin
              r_cnt <= '0;
              r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        LOAD: r_state <= HOLD;
        HOLD: if (bus.img_ack) r_state <= FILL;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Random + directed bench for image_loader against a frame-level model.
// Second instance covers the full-size 784-word image.
module tb_image_loader;
  import fnn_pkg::*;

  localparam int N  = 4;
  localparam int BN = 784;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  image_loader_if #(.weightNo(N), .dataWidth(16)) bus ();
  image_loader_if #(.weightNo(BN), .dataWidth(16)) big ();

  image_loader #(.weightNo(N), .dataWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  image_loader #(.weightNo(BN), .dataWidth(16)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (big)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Frame-level model: words collected so far, and the expected outputs.
  logic [15:0]     frame[$];
  logic [N*16-1:0] exp_img;
  logic            exp_ready, exp_busy, exp_load, exp_err;
  bit              m_idle;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_img   = '0;
    exp_ready = 0;
    exp_busy  = 0;
    exp_load  = 0;
    exp_err   = 0;
    m_idle    = 1;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d,
                            input logic l, input logic a);
    logic acc, nl, ne, nb, nr, leave;
    acc = exp_ready && v;
    nl = 0;
    ne = 0;
    if (acc) begin
      exp_img[frame.size()*16 +: 16] = d;
      frame.push_back(d);
      if (frame.size() == N) begin
        nl = 1;
        frame.delete();
      end else if (l) begin
        ne = 1;
        frame.delete();
      end
    end
    leave = exp_busy && !exp_load && a;
    if (m_idle) begin
      nr = 1;
      nb = 0;
      m_idle = 0;
    end else begin
      nb = nl || (exp_busy && !leave);
      nr = (exp_ready && !nl) || leave;
    end
    exp_ready = nr;
    exp_busy  = nb;
    exp_load  = nl;
    exp_err   = ne;
  endtask

  task automatic cyc(input logic v, input logic [15:0] d,
                     input logic l, input logic a);
    bus.pix_valid = v;
    bus.pix_in    = d;
    bus.pix_last  = l;
    bus.img_ack   = a;
    @(posedge clk);
    if (!rst) model_step(v, d, l, a);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    model_reset();
    repeat (n) cyc(1, 16'h1111, 0, 0);
    rst = 0;
  endtask

  task automatic frame14(input bit bubbles);
    for (int k = 1; k <= N; k++) begin
      if (bubbles) cyc(0, 16'hDEAD, 0, 0);
      cyc(1, 16'(k), k == N, 0);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("pix_ready", 64'(bus.pix_ready), 64'(exp_ready));
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      chk("img_load", 64'(bus.img_load), 64'(exp_load));
      chk("frame_err", 64'(bus.frame_err), 64'(exp_err));
      chk("img_out", bus.img_out, exp_img);
    end
  end

  logic [15:0] bw[BN];
  int bad, first_bad;

  initial begin
    bus.pix_valid = 0;
    bus.pix_in = 0;
    bus.pix_last = 0;
    bus.img_ack = 0;
    big.pix_valid = 0;
    big.pix_in = 0;
    big.pix_last = 0;
    big.img_ack = 0;
    model_reset();
    @(negedge clk);
    chk_en = 1;

    // 1. reset with valid held high
    do_reset(3);
    #1 chk("ready_after_deassert", 64'(bus.pix_ready), 64'd0);
    cyc(1, 16'h1111, 0, 0);
    #1 chk("ready_first_clk", 64'(bus.pix_ready), 64'd1);
    chk("no_early_beat", bus.img_out, 64'd0);

    // 2. full frame
    frame14(0);
    #1 chk("load_pulse", 64'(bus.img_load), 64'd1);
    chk("frame_img", bus.img_out, 64'h0004_0003_0002_0001);
    repeat (4) cyc(0, 0, 0, 0);
    #1 chk("hold_busy", 64'(bus.busy), 64'd1);
    chk("hold_ready", 64'(bus.pix_ready), 64'd0);
    cyc(0, 0, 0, 1);

    // 3. bubbles
    do_reset(2);
    cyc(0, 0, 0, 0);
    frame14(1);
    #1 chk("bubble_load", 64'(bus.img_load), 64'd1);
    chk("bubble_img", bus.img_out, 64'h0004_0003_0002_0001);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // 4. early last
    cyc(1, 16'hAAAA, 0, 0);
    cyc(1, 16'hBBBB, 1, 0);
    #1 chk("early_err", 64'(bus.frame_err), 64'd1);
    chk("early_noload", 64'(bus.img_load), 64'd0);
    frame14(0);
    chk("after_err_img", bus.img_out, 64'h0004_0003_0002_0001);
    cyc(0, 0, 0, 0);

    // 5. back-pressure in HOLD
    repeat (10) cyc(1, 16'h0055, 0, 0);
    chk("bp_img", bus.img_out, 64'h0004_0003_0002_0001);
    cyc(1, 16'h0055, 0, 1);
    cyc(1, 16'h0055, 0, 0);
    chk("bp_beat", bus.img_out, 64'h0004_0003_0002_0055);
    cyc(0, 0, 0, 0);

    // 6. mid-frame async reset
    cyc(1, 16'h0007, 0, 0);
    bus.pix_in = 16'h0008;
    #2 rst = 1;
    model_reset();
    #1 chk("midrst_img", bus.img_out, 64'd0);
    chk("midrst_ready", 64'(bus.pix_ready), 64'd0);
    @(negedge clk);
    cyc(0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    frame14(0);
    chk("post_rst_img", bus.img_out, 64'h0004_0003_0002_0001);
    cyc(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(9) < 7, 16'($urandom),
          $urandom_range(7) == 0, $urandom_range(9) < 3);
    end
    chk_en = 0;

    // full-size instance: mid-frame reset then a full frame
    rst2 = 0;
    @(negedge clk);
    big.pix_valid = 1;
    big.pix_in = 16'h1234;
    repeat (2) @(negedge clk);
    #2 rst2 = 1;
    #1 chk("big_rst_img", 64'(big.img_out == '0), 64'd1);
    chk("big_rst_ready", 64'(big.pix_ready), 64'd0);
    big.pix_valid = 0;
    @(negedge clk);
    rst2 = 0;
    @(negedge clk);
    for (int k = 0; k < BN; k++) begin
      bw[k] = 16'($urandom);
      big.pix_valid = 1;
      big.pix_in = bw[k];
      big.pix_last = (k == BN - 1);
      @(negedge clk);
    end
    big.pix_valid = 0;
    big.pix_last = 0;
    #1 chk("big_load", 64'(big.img_load), 64'd1);
    chk("big_busy", 64'(big.busy), 64'd1);
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < BN; k++) begin
      if (big.img_out[k*16 +: 16] !== bw[k]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk("big_img_words_bad", 64'(bad), 64'd0);
    if (bad != 0) $display("  first bad word index %0d", first_bad);
    @(negedge clk);
    #1 chk("big_load_once", 64'(big.img_load), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
